// File: rtl/sample_mem.sv
// Capture buffer for 32-bit samples: a circular write phase followed by a
// newest-first readback phase, backed by a single-port synchronous RAM.
module sample_mem #(
    parameter int unsigned MEMORY_DEPTH = 6
) (
    input  logic        clock,
    input  logic        resetn,
    input  logic        clear,
    input  logic [31:0] memoryWrData,
    input  logic        memoryWrite,
    input  logic        memoryLastWrite,
    input  logic        memoryRead,
    output logic [31:0] rdData,
    output logic        rdValid,
    output logic        wrapped,
    output logic        readDone,
    output logic        underrun
);

    localparam int unsigned N  = 1 << MEMORY_DEPTH;
    localparam int unsigned CW = MEMORY_DEPTH + 1;
    localparam logic [CW-1:0] NWords = CW'(N);

    typedef enum logic [1:0] {StIdle, StCapture, StReadout, StDone} state_e;

    state_e                  state_q, state_d;
    logic [MEMORY_DEPTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [MEMORY_DEPTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]           count_q, count_d;
    logic [CW-1:0]           remaining_q, remaining_d;
    logic                    read_done_q, read_done_d;
    logic                    underrun_q, underrun_d;
    logic                    rd_valid_q, rd_valid_d;
    // Set when the last returned word came from the RAM, clear for underrun zeros.
    logic                    rd_hit_q, rd_hit_d;
    logic                    mem_we, mem_re;

    logic [31:0] mem [N];
    logic [31:0] ram_q;

    // Next-state, pointer and flag logic; clear overrides every other input.
    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        remaining_d = remaining_q;
        read_done_d = read_done_q;
        underrun_d  = underrun_q;
        rd_hit_d    = rd_hit_q;
        rd_valid_d  = 1'b0;
        mem_we      = 1'b0;
        mem_re      = 1'b0;
        if (clear) begin
            state_d     = StIdle;
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            count_d     = '0;
            remaining_d = '0;
            read_done_d = 1'b0;
            underrun_d  = 1'b0;
        end else begin
            unique case (state_q)
                StIdle, StCapture: begin
                    if (memoryWrite) begin
                        mem_we   = 1'b1;
                        wr_ptr_d = wr_ptr_q + 1'b1;
                        if (count_q != NWords) begin
                            count_d = count_q + 1'b1;
                        end
                        state_d = StCapture;
                    end
                    // A same-cycle write is already folded into wr_ptr_d/count_d.
                    if (memoryLastWrite) begin
                        state_d     = StReadout;
                        rd_ptr_d    = wr_ptr_d - 1'b1;
                        remaining_d = count_d;
                    end
                end
                StReadout: begin
                    if (memoryRead) begin
                        rd_valid_d = 1'b1;
                        if (remaining_q != '0) begin
                            mem_re      = 1'b1;
                            rd_hit_d    = 1'b1;
                            rd_ptr_d    = rd_ptr_q - 1'b1;
                            remaining_d = remaining_q - 1'b1;
                            if (remaining_q == CW'(1)) begin
                                state_d     = StDone;
                                read_done_d = 1'b1;
                            end
                        end else begin
                            rd_hit_d   = 1'b0;
                            underrun_d = 1'b1;
                        end
                    end
                end
                StDone: begin
                    if (memoryRead) begin
                        rd_valid_d = 1'b1;
                        rd_hit_d   = 1'b0;
                        underrun_d = 1'b1;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    // Control and flag registers with asynchronous active-low reset.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q     <= StIdle;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            remaining_q <= '0;
            read_done_q <= 1'b0;
            underrun_q  <= 1'b0;
            rd_valid_q  <= 1'b0;
            rd_hit_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            remaining_q <= remaining_d;
            read_done_q <= read_done_d;
            underrun_q  <= underrun_d;
            rd_valid_q  <= rd_valid_d;
            rd_hit_q    <= rd_hit_d;
        end
    end

    // Single-port RAM: write during capture, registered read during readout.
    always_ff @(posedge clock) begin
        if (mem_we) begin
            mem[wr_ptr_q] <= memoryWrData;
        end
        if (mem_re) begin
            ram_q <= mem[rd_ptr_q];
        end
    end

    // Outputs are taken from registers only; rd_hit_q masks stale/undefined RAM data.
    assign rdData   = rd_hit_q ? ram_q : 32'h0;
    assign rdValid  = rd_valid_q;
    assign wrapped  = (count_q == NWords);
    assign readDone = read_done_q;
    assign underrun = underrun_q;

endmodule

// File: tb/tb_sample_mem.sv
// Self-checking bench for sample_mem: directed scenarios plus randomized
// capture/readback rounds checked against a queue-based reference model.
module tb_sample_mem;

    localparam int unsigned DEPTH = 6;
    localparam int unsigned N     = 1 << DEPTH;

    logic        clock;
    logic        resetn;
    logic        clear;
    logic [31:0] memoryWrData;
    logic        memoryWrite;
    logic        memoryLastWrite;
    logic        memoryRead;
    logic [31:0] rdData;
    logic        rdValid;
    logic        wrapped;
    logic        readDone;
    logic        underrun;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: words written since clear, and the pending readback list.
    logic [31:0] hist[$];
    logic [31:0] expq[$];
    bit          m_readout;
    bit          m_done;
    bit          m_underrun;
    int          m_total;

    sample_mem #(.MEMORY_DEPTH(DEPTH)) dut (
        .clock           (clock),
        .resetn          (resetn),
        .clear           (clear),
        .memoryWrData    (memoryWrData),
        .memoryWrite     (memoryWrite),
        .memoryLastWrite (memoryLastWrite),
        .memoryRead      (memoryRead),
        .rdData          (rdData),
        .rdValid         (rdValid),
        .wrapped         (wrapped),
        .readDone        (readDone),
        .underrun        (underrun)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_clear();
        hist.delete();
        expq.delete();
        m_readout  = 1'b0;
        m_done     = 1'b0;
        m_underrun = 1'b0;
        m_total    = 0;
    endtask

    // One clock of stimulus; the model is advanced and every output checked.
    task automatic cycle(input bit w, input logic [31:0] d, input bit lw, input bit rd,
                         input bit clr);
        bit          exp_valid;
        logic [31:0] exp_data;
        exp_valid = 1'b0;
        exp_data  = 32'h0;
        @(negedge clock);
        memoryWrite     = w;
        memoryWrData    = d;
        memoryLastWrite = lw;
        memoryRead      = rd;
        clear           = clr;
        @(posedge clock);
        #1;
        if (clr) begin
            model_clear();
        end else if (!m_readout) begin
            if (w) begin
                hist.push_back(d);
                if (hist.size() > N) void'(hist.pop_front());
                m_total++;
            end
            if (lw) begin
                expq.delete();
                for (int i = hist.size() - 1; i >= 0; i--) expq.push_back(hist[i]);
                m_readout = 1'b1;
            end
        end else if (rd) begin
            exp_valid = 1'b1;
            if (expq.size() > 0) begin
                exp_data = expq.pop_front();
                if (expq.size() == 0) m_done = 1'b1;
            end else begin
                m_underrun = 1'b1;
            end
        end
        check_eq("rdValid", {31'b0, rdValid}, {31'b0, exp_valid});
        if (exp_valid) check_eq("rdData", rdData, exp_data);
        check_eq("wrapped", {31'b0, wrapped}, {31'b0, (m_total >= N)});
        check_eq("readDone", {31'b0, readDone}, {31'b0, m_done});
        check_eq("underrun", {31'b0, underrun}, {31'b0, m_underrun});
    endtask

    task automatic idle();
        cycle(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic check_outputs_zero(input string tag);
        check_eq({tag, "_rdData"}, rdData, 32'h0);
        check_eq({tag, "_rdValid"}, {31'b0, rdValid}, 32'h0);
        check_eq({tag, "_wrapped"}, {31'b0, wrapped}, 32'h0);
        check_eq({tag, "_readDone"}, {31'b0, readDone}, 32'h0);
        check_eq({tag, "_underrun"}, {31'b0, underrun}, 32'h0);
    endtask

    initial begin
        int nw;
        int nr;
        bit comb;
        resetn          = 1'b0;
        clear           = 1'b0;
        memoryWrData    = 32'h0;
        memoryWrite     = 1'b0;
        memoryLastWrite = 1'b0;
        memoryRead      = 1'b0;
        model_clear();
        #12;
        check_outputs_zero("reset");
        @(negedge clock);
        resetn = 1'b1;

        // Simple capture of 0..9, newest first.
        for (int i = 0; i < 10; i++) cycle(1'b1, 32'(i), 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            cycle(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
            check_eq("simple_word", rdData, 32'(9 - i));
        end
        check_eq("simple_done", {31'b0, readDone}, 32'h1);

        // Wrap: 100 writes, only the newest 64 come back.
        cycle(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 100; i++) cycle(1'b1, 32'(i), 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 64; i++) begin
            cycle(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
            check_eq("wrap_word", rdData, 32'(99 - i));
        end

        // Final write carries LastWrite.
        cycle(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) cycle(1'b1, 32'(i), (i == 4), 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) cycle(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);

        // Underrun after full readback; write in DONE is ignored.
        cycle(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) cycle(1'b1, 32'hA0 + 32'(i), 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) cycle(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
        check_eq("underrun_set", {31'b0, underrun}, 32'h1);
        cycle(1'b1, 32'hDEAD, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);

        // Clear wins over a simultaneous write and read in READOUT.
        cycle(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) cycle(1'b1, 32'h10 + 32'(i), (i == 3), 1'b0, 1'b0);
        cycle(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
        cycle(1'b1, 32'h55, 1'b0, 1'b1, 1'b1);
        idle();
        cycle(1'b1, 32'h77, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 32'h88, 1'b1, 1'b0, 1'b0);
        cycle(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
        check_eq("clr_new0", rdData, 32'h88);
        cycle(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
        check_eq("clr_new1", rdData, 32'h77);

        // Randomized rounds, including an empty capture.
        for (int it = 0; it < 8; it++) begin
            cycle(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
            nw   = (it == 0) ? 0 : int'($urandom_range(1, 150));
            comb = ($urandom_range(0, 1) == 1);
            for (int k = 0; k < nw; k++) begin
                if ($urandom_range(0, 3) == 0) cycle(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
                cycle(1'b1, $urandom, comb && (k == nw - 1), 1'b0, 1'b0);
            end
            if (!comb || nw == 0) cycle(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
            nr = ((nw < int'(N)) ? nw : int'(N)) + int'($urandom_range(0, 2));
            for (int r = 0; r < nr; r++) begin
                if ($urandom_range(0, 4) == 0) idle();
                cycle(1'($urandom_range(0, 1)), $urandom, 1'b0, 1'b1, 1'b0);
            end
        end

        // Asynchronous reset in the middle of a readback.
        cycle(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 6; i++) cycle(1'b1, 32'h100 + 32'(i), (i == 5), 1'b0, 1'b0);
        cycle(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
        #2;
        resetn = 1'b0;
        #1;
        check_outputs_zero("async_reset");
        @(posedge clock);
        #1;
        check_eq("reset_hold_valid", {31'b0, rdValid}, 32'h0);
        @(negedge clock);
        memoryRead = 1'b0;
        resetn     = 1'b1;
        model_clear();
        cycle(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
        cycle(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
